// File: rtl/calc1_req_sequencer.sv
// Sequences one request at a time into a calc1 port: command+operand 1, then operand 2, then waits for the response.
// Optional timeout completion (rsp_code 3) is compiled in by defining CALC1_SEQ_TIMEOUT_EN.
module calc1_req_sequencer #(
    parameter int TIMEOUT = 15
) (
    input  logic        c_clk,
    input  logic        reset,
    // Both handshakes: a transfer happens at a rising edge where valid && ready;
    // the sender holds its payload stable while valid is high and ready is low.
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [0:3]  req_cmd,
    input  logic [0:31] req_op1,
    input  logic [0:31] req_op2,
    output logic [0:3]  cmd_out,
    output logic [0:31] data_out,
    input  logic [0:1]  resp_in,
    input  logic [0:31] data_in,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [0:1]  rsp_code,
    output logic [0:31] rsp_data,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SEND_OP1 = 3'd1,
        S_SEND_OP2 = 3'd2,
        S_WAIT     = 3'd3,
        S_HOLD     = 3'd4
    } state_t;

    state_t      state;
    logic [0:31] op2_q;

`ifdef CALC1_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] tmo_cnt;
`endif

    assign req_ready = (state == S_IDLE);
    assign state_dbg = state;

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cmd_out   <= '0;
            data_out  <= '0;
            op2_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_code  <= '0;
            rsp_data  <= '0;
`ifdef CALC1_SEQ_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    // Command and operand 1 go straight into the output registers,
                    // so calc1 sees them the cycle after acceptance.
                    if (req_valid) begin
                        cmd_out  <= req_cmd;
                        data_out <= req_op1;
                        op2_q    <= req_op2;
                        state    <= S_SEND_OP1;
                    end
                end
                S_SEND_OP1: begin
                    cmd_out  <= '0;
                    data_out <= op2_q;
                    state    <= S_SEND_OP2;
                end
                S_SEND_OP2: begin
                    data_out <= '0;
                    state    <= S_WAIT;
`ifdef CALC1_SEQ_TIMEOUT_EN
                    tmo_cnt  <= '0;
`endif
                end
                S_WAIT: begin
                    // A response is checked first so it wins over a same-cycle expiry.
                    if (resp_in != 2'b00) begin
                        rsp_valid <= 1'b1;
                        rsp_code  <= resp_in;
                        rsp_data  <= data_in;
                        state     <= S_HOLD;
                    end
`ifdef CALC1_SEQ_TIMEOUT_EN
                    else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
                            rsp_valid <= 1'b1;
                            rsp_code  <= 2'd3;
                            rsp_data  <= '0;
                            state     <= S_HOLD;
                        end
                    end
`endif
                end
                S_HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc1_req_sequencer.sv
// Bench for calc1_req_sequencer: directed vector table, reset-abort sequence and randomized
// transactions against a calc1 stand-in model; timeout expectations follow CALC1_SEQ_TIMEOUT_EN.
module tb_calc1_req_sequencer;

    localparam int TIMEOUT = 15;

    logic        c_clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [0:3]  req_cmd;
    logic [0:31] req_op1;
    logic [0:31] req_op2;
    logic [0:3]  cmd_out;
    logic [0:31] data_out;
    logic [0:1]  resp_in;
    logic [0:31] data_in;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:1]  rsp_code;
    logic [0:31] rsp_data;
    logic [2:0]  state_dbg;

    int n_vec = 0;
    int n_bad = 0;

    calc1_req_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .c_clk(c_clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_op1(req_op1), .req_op2(req_op2),
        .cmd_out(cmd_out), .data_out(data_out),
        .resp_in(resp_in), .data_in(data_in),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_code(rsp_code), .rsp_data(rsp_data),
        .state_dbg(state_dbg)
    );

    always #5 c_clk = ~c_clk;

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [1:0]  resp;      // calc1 response code
        logic [31:0] rdata;     // calc1 response data
        int          delay;     // WAIT cycle index in which calc1 answers
        int          hold;      // HOLD cycles with rsp_ready low
        bit          noise;     // drive a bogus response while the operands go out
        logic [1:0]  exp_code;
        logic [31:0] exp_data;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge c_clk);
        #1;
    endtask

    // calc1 stand-in: arithmetic result, error (2) on overflow/underflow/unknown command.
    function automatic void calc1_model(input logic [3:0] cmd, input logic [31:0] a,
                                        input logic [31:0] b, output logic [1:0] resp,
                                        output logic [31:0] d);
        logic [32:0] s;
        resp = 2'd2;
        d    = '0;
        case (cmd)
            4'd1: begin
                s = {1'b0, a} + {1'b0, b};
                if (!s[32]) begin resp = 2'd1; d = s[31:0]; end
            end
            4'd2: if (a >= b) begin resp = 2'd1; d = a - b; end
            4'd5: begin resp = 2'd1; d = a << b[4:0]; end
            4'd6: begin resp = 2'd1; d = a >> b[4:0]; end
            default: ;
        endcase
    endfunction

    // What the sequencer must report when calc1 answers in WAIT cycle 'delay'.
    function automatic void expect_rsp(input logic [1:0] resp, input logic [31:0] d,
                                       input int delay, output logic [1:0] code,
                                       output logic [31:0] ed);
        code = resp;
        ed   = d;
`ifdef CALC1_SEQ_TIMEOUT_EN
        if (delay >= TIMEOUT) begin code = 2'd3; ed = '0; end
`endif
    endfunction

    task automatic run_txn(input vec_t v);
        int k;
        int wait_cycles;
        k = 0;
        while (req_ready !== 1'b1 && k < 20) begin step(); k++; end
        check("req_ready_idle", 32'(req_ready), 32'd1);

        req_valid = 1'b1;
        req_cmd   = v.cmd;
        req_op1   = v.op1;
        req_op2   = v.op2;
        if (v.noise) begin resp_in = 2'd2; data_in = 32'hDEAD_BEEF; end
        step();
        req_valid = 1'b0;
        req_cmd   = 4'($urandom);
        req_op1   = $urandom;
        req_op2   = $urandom;
        check("op1_cmd", 32'(cmd_out), 32'(v.cmd));
        check("op1_data", data_out, v.op1);
        check("req_ready_busy", 32'(req_ready), 32'd0);
        step();
        check("op2_cmd", 32'(cmd_out), 32'd0);
        check("op2_data", data_out, v.op2);
        check("op2_no_rsp", 32'(rsp_valid), 32'd0);
        step();
        resp_in = 2'd0;
        data_in = '0;
        check("wait_cmd", 32'(cmd_out), 32'd0);
        check("wait_data", data_out, 32'd0);
        check("wait_state", 32'(state_dbg), 32'd3);
        check("wait_no_rsp", 32'(rsp_valid), 32'd0);

        wait_cycles = (v.exp_code == 2'd3) ? TIMEOUT : v.delay + 1;
        for (int c = 0; c < wait_cycles; c++) begin
            if (c == v.delay) begin resp_in = v.resp; data_in = v.rdata; end
            step();
            resp_in = 2'd0;
            data_in = $urandom;
            if (c < wait_cycles - 1) check("wait_pending", 32'(rsp_valid), 32'd0);
        end

        for (int h = 0; h <= v.hold; h++) begin
            rsp_ready = (h == v.hold);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_code", 32'(rsp_code), 32'(v.exp_code));
            check("hold_data", rsp_data, v.exp_data);
            check("hold_req_ready", 32'(req_ready), 32'd0);
            step();
        end
        rsp_ready = 1'b0;
        check("release_valid", 32'(rsp_valid), 32'd0);
        check("release_req_ready", 32'(req_ready), 32'd1);
    endtask

    vec_t tbl[8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        v;
        logic [1:0]  ec;
        logic [31:0] ed;
        int          sel;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_cmd   = '0;
        req_op1   = '0;
        req_op2   = '0;
        resp_in   = '0;
        data_in   = '0;
        rsp_ready = 1'b0;
        #2 reset = 1'b0;
        step();
        check("rst_cmd_out", 32'(cmd_out), 32'd0);
        check("rst_data_out", data_out, 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_code", 32'(rsp_code), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        step();
        reset = 1'b1;
        step();
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_state", 32'(state_dbg), 32'd0);

        tbl[0] = '{4'd1, 32'h0000_0001, 32'h01FF_FFFF, 2'd1, 32'h0200_0000, 2, 0, 1'b0, 2'd1, 32'h0200_0000};
        tbl[1] = '{4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0, 1, 0, 1'b0, 2'd2, 32'h0};
        tbl[2] = '{4'd2, 32'd10, 32'd3, 2'd1, 32'd7, 0, 6, 1'b0, 2'd1, 32'd7};
        tbl[3] = '{4'd3, 32'h1, 32'h0, 2'd2, 32'h0, 3, 1, 1'b0, 2'd2, 32'h0};
        tbl[4] = '{4'd5, 32'h1, 32'h4, 2'd1, 32'h10, 4, 0, 1'b1, 2'd1, 32'h10};
        tbl[5] = '{4'd6, 32'h80, 32'h3, 2'd1, 32'h10, 14, 0, 1'b0, 2'd1, 32'h10};
`ifdef CALC1_SEQ_TIMEOUT_EN
        tbl[6] = '{4'd1, 32'h2, 32'h3, 2'd1, 32'h5, 15, 0, 1'b0, 2'd3, 32'h0};
        tbl[7] = '{4'd1, 32'h4, 32'h4, 2'd1, 32'h8, 100, 2, 1'b0, 2'd3, 32'h0};
`else
        tbl[6] = '{4'd1, 32'h2, 32'h3, 2'd1, 32'h5, 15, 0, 1'b0, 2'd1, 32'h5};
        tbl[7] = '{4'd1, 32'h4, 32'h4, 2'd1, 32'h8, 100, 2, 1'b0, 2'd1, 32'h8};
`endif
        foreach (tbl[i]) run_txn(tbl[i]);

        // Reset while waiting on calc1, then a late response after release.
        req_valid = 1'b1;
        req_cmd   = 4'd1;
        req_op1   = 32'h11;
        req_op2   = 32'h22;
        step();
        req_valid = 1'b0;
        step();
        step();
        step();
        check("abort_in_wait", 32'(state_dbg), 32'd3);
        reset = 1'b0;
        #1;
        check("abort_cmd_out", 32'(cmd_out), 32'd0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_state", 32'(state_dbg), 32'd0);
        step();
        reset = 1'b1;
        step();
        resp_in = 2'd1;
        data_in = 32'h1234_5678;
        step();
        resp_in = 2'd0;
        data_in = '0;
        for (int i = 0; i < 3; i++) begin
            check("late_rsp_valid", 32'(rsp_valid), 32'd0);
            check("late_req_ready", 32'(req_ready), 32'd1);
            check("late_cmd_out", 32'(cmd_out), 32'd0);
            check("late_rsp_code", 32'(rsp_code), 32'd0);
            step();
        end

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0: v.cmd = 4'd1;
                1: v.cmd = 4'd2;
                2: v.cmd = 4'd5;
                3: v.cmd = 4'd6;
                default: v.cmd = 4'($urandom_range(0, 15));
            endcase
            v.op1   = $urandom;
            v.op2   = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
            calc1_model(v.cmd, v.op1, v.op2, v.resp, v.rdata);
            v.delay = $urandom_range(0, 20);
            v.hold  = $urandom_range(0, 3);
            v.noise = 1'($urandom_range(0, 1));
            expect_rsp(v.resp, v.rdata, v.delay, ec, ed);
            v.exp_code = ec;
            v.exp_data = ed;
            run_txn(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
